lmk_uwire_master: RTL and testbench

LMK_UWIRE_MASTER -- requirements
Module: lmk_uwire_master

---
 rtl/lmk_uwire_master.sv | 150 +++++++++++++++
 tb/tb_lmk_uwire_master.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lmk_uwire_master.sv
// MICROWIRE write master for the LMK01801 clock buffer.
// Define LMK_UWIRE_READBACK_EN to capture uwire_din into rdata.
module lmk_uwire_master #(
  parameter int unsigned DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        uwire_clk,
  output logic        uwire_data,
  output logic        uwire_le,
  input  logic        uwire_din,
  output logic [31:0] rdata
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH,
    GAP
  } state_e;

  localparam logic [7:0] RLD = 8'(DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic        ph_q, ph_d;
  logic [31:0] sh_q, sh_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        clk_q, clk_d;
  logic        data_q, data_d;
  logic        le_q, le_d;
  logic        tick;
  logic        last;

  assign tick = (cnt_q == 8'd0);
  // last cycle of the high (second) half of a bit/LATCH/GAP slot
  assign last = tick & ph_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 5'd31;
      ph_q    <= 1'b0;
      sh_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clk_q   <= 1'b0;
      data_q  <= 1'b0;
      le_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      sh_q    <= sh_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clk_q   <= clk_d;
      data_q  <= data_d;
      le_q    <= le_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    ph_d    = ph_q;
    sh_d    = sh_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          sh_d    = wdata;
          bit_d   = 5'd31;
          cnt_d   = RLD;
          ph_d    = 1'b0;
        end
      end
      default: begin
        if (!tick) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          cnt_d = RLD;
          ph_d  = ~ph_q;
        end
        if (last) begin
          unique case (state_q)
            SHIFT: begin
              if (bit_q == 5'd0) state_d = LATCH;
              else bit_d = bit_q - 5'd1;
            end
            LATCH:   state_d = GAP;
            default: state_d = IDLE;
          endcase
        end
      end
    endcase
  end

  // outputs are decoded from next-state so every pin comes straight off a flop
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_q == GAP) & last;
    clk_d  = (state_d == SHIFT) & ph_d;
    data_d = (state_d == SHIFT) & sh_d[bit_d];
    le_d   = (state_d == LATCH);
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign uwire_clk  = clk_q;
  assign uwire_data = data_q;
  assign uwire_le   = le_q;

`ifdef LMK_UWIRE_READBACK_EN
  logic [31:0] rx_q, rx_d;
  logic [31:0] rd_q, rd_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q <= 32'd0;
      rd_q <= 32'd0;
    end else begin
      rx_q <= rx_d;
      rd_q <= rd_d;
    end
  end

  always_comb begin
    rx_d = rx_q;
    if ((state_q == SHIFT) && last) rx_d = {rx_q[30:0], uwire_din};
    rd_d = done_d ? rx_q : rd_q;
  end

  assign rdata = rd_q;
`else
  logic unused_din;
  assign unused_din = uwire_din;
  assign rdata      = 32'd0;
`endif

endmodule

// File: tb/tb_lmk_uwire_master.sv
// Directed bench for lmk_uwire_master: DIV=4 and DIV=1 instances.
// Readback expectations follow LMK_UWIRE_READBACK_EN.
module tb_lmk_uwire_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] wdata;
  logic        sel;

  logic        busy4, done4, uwc4, uwd4, uwl4, din4;
  logic [31:0] rd4;
  logic        busy1, done1, uwc1, uwd1, uwl1;
  logic [31:0] rd1;

  logic        m_busy, m_done, m_clk, m_data, m_le;
  logic [31:0] m_rd;
  logic        rb_clr;
  logic [31:0] rb_sh;
  logic [31:0] last_rd;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lmk_uwire_master #(.DIV(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .wdata(wdata),
    .busy(busy4), .done(done4), .uwire_clk(uwc4), .uwire_data(uwd4),
    .uwire_le(uwl4), .uwire_din(din4), .rdata(rd4)
  );

  lmk_uwire_master #(.DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .wdata(wdata),
    .busy(busy1), .done(done1), .uwire_clk(uwc1), .uwire_data(uwd1),
    .uwire_le(uwl1), .uwire_din(1'b0), .rdata(rd1)
  );

  // device model: presents the next readback bit on each uwire_clk rise
  always @(posedge uwc4 or posedge rb_clr) begin
    if (rb_clr) begin
      rb_sh <= 32'hC0FF_EE01;
      din4  <= 1'b0;
    end else begin
      din4  <= rb_sh[31];
      rb_sh <= {rb_sh[30:0], 1'b0};
    end
  end

  always_comb begin
    m_busy = sel ? busy1 : busy4;
    m_done = sel ? done1 : done4;
    m_clk  = sel ? uwc1  : uwc4;
    m_data = sel ? uwd1  : uwd4;
    m_le   = sel ? uwl1  : uwl4;
    m_rd   = sel ? rd1   : rd4;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] w);
    start = 1'b1;
    wdata = w;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic mon(input string tg, input logic [31:0] exp_w,
                     input int pulse_at, input logic b2b,
                     input logic [31:0] w2);
    int nb, nhi, nrise, nle, nlerise, ndone, nbad, nrd, div;
    logic [31:0] word;
    logic pc, pd, pl, first;
    nb = 0; nhi = 0; nrise = 0; nle = 0; nlerise = 0;
    ndone = 0; nbad = 0; nrd = 0;
    word = 32'd0; pc = 0; pd = 0; pl = 0; first = 1;
    div = sel ? 1 : 4;
    for (int k = 0; k < 2000; k++) begin
      if (m_rd != 32'd0) nrd++;
      if (m_done) ndone++;
      if (!m_busy) break;
      nb++;
      if (m_clk) nhi++;
      if (m_clk && !pc) begin
        nrise++;
        word = {word[30:0], m_data};
      end
      if (m_le && !pl) nlerise++;
      if (m_le) begin
        nle++;
        if (m_data || m_clk) nbad++;
      end
      if (!first && (m_data != pd) && !(pc && !m_clk)) nbad++;
      pc = m_clk; pd = m_data; pl = m_le; first = 0;
      if (pulse_at >= 0) begin
        start = (k == pulse_at);
        wdata = 32'h1234_5678;
      end
      @(negedge clk);
    end
    start = 1'b0;
    last_rd = m_rd;
    check({tg, ".done"}, m_done, 1);
    check({tg, ".idle_pins"}, {m_clk, m_data, m_le}, 0);
    if (b2b) begin
      start = 1'b1;
      wdata = w2;
      @(negedge clk);
      start = 1'b0;
    end else begin
      repeat (3) begin
        @(negedge clk);
        if (m_done) ndone++;
      end
    end
    check({tg, ".busy_cyc"}, nb, 68 * div);
    check({tg, ".word"}, word, exp_w);
    check({tg, ".rises"}, nrise, 32);
    check({tg, ".hi_cyc"}, nhi, 32 * div);
    check({tg, ".le_cyc"}, nle, 2 * div);
    check({tg, ".le_pulses"}, nlerise, 1);
    check({tg, ".done_pulses"}, ndone, 1);
    check({tg, ".bad_edges"}, nbad, 0);
`ifndef LMK_UWIRE_READBACK_EN
    check({tg, ".rdata_nz"}, nrd, 0);
`endif
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    wdata  = 32'd0;
    sel    = 1'b0;
    rb_clr = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.dut4", {busy4, done4, uwc4, uwd4, uwl4, rd4}, 0);
    check("rst.dut1", {busy1, done1, uwc1, uwd1, uwl1, rd1}, 0);
    rst_n  = 1'b1;
    rb_clr = 1'b0;
    @(negedge clk);

    send(32'h8000_0011);
    mon("f4", 32'h8000_0011, -1, 1'b0, 32'd0);

    send(32'hAAAA_AAAA);
    mon("repulse", 32'hAAAA_AAAA, 100, 1'b0, 32'd0);

    send(32'hA5A5_A5A5);
    repeat (130) @(negedge clk);
    check("abort.busy_before", busy4, 1);
    rst_n = 1'b0;
    #1;
    check("abort.outs", {busy4, done4, uwc4, uwd4, uwl4, rd4}, 0);
    begin
      int nev;
      nev = 0;
      repeat (5) begin
        @(negedge clk);
        if (uwl4 || done4 || busy4) nev++;
      end
      check("abort.quiet", nev, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    send(32'h5A5A_0FF0);
    mon("after_rst", 32'h5A5A_0FF0, -1, 1'b0, 32'd0);

    rb_clr = 1'b1;
    @(negedge clk);
    rb_clr = 1'b0;
    send(32'h0F0F_1234);
    mon("rb", 32'h0F0F_1234, -1, 1'b0, 32'd0);
`ifdef LMK_UWIRE_READBACK_EN
    check("rb.rdata_done", last_rd, 32'hC0FF_EE01);
    check("rb.rdata_hold", rd4, 32'hC0FF_EE01);
`else
    check("rb.rdata_done", last_rd, 32'd0);
    check("rb.rdata_hold", rd4, 32'd0);
`endif

    sel = 1'b1;
    @(negedge clk);
    send(32'hFFFF_FFFF);
    mon("b2b0", 32'hFFFF_FFFF, -1, 1'b1, 32'h0000_0000);
    check("b2b.no_gap", busy1, 1);
    mon("b2b1", 32'h0000_0000, -1, 1'b0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
